sumador_sat_acc: RTL

Registered, parametrised successor to the combinational saturating adder. It performs signed two's-complement add, subtract or accumulate on WIDTH-bit fixed-point operands, with per-result saturation to the representable range. It adds a valid handshake, a sticky overflow flag and a saturating overflow-event counter. It sits in the fixed-point datapath between filter/multiplier stages and the output register stage.

---
 rtl/sumador_pkg.sv | 21 ++
 rtl/sumador_sat_acc_sat_addsub.sv | 37 +++
 rtl/sumador_sat_acc.sv | 87 ++++++++
 3 files changed

// File: rtl/sumador_pkg.sv
// Shared definitions for the registered saturating adder/accumulator:
// mode encoding and saturation limit helpers.
package sumador_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Limits are returned in 64 bits; callers keep the low WIDTH bits.
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sumador_sat_acc_sat_addsub.sv
// Combinational signed add/subtract with overflow detection and optional
// clamping to the representable WIDTH-bit range.
module sat_addsub
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH  = 22,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam logic [63:0]      MAX64 = sat_max(WIDTH);
    localparam logic [63:0]      MIN64 = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] MAX_V = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_V = MIN64[WIDTH-1:0];

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] sum;

    // One guard bit makes A-MIN overflow detectable without negating B.
    always_comb begin
        ext_a = {a[WIDTH-1], a};
        ext_b = {b[WIDTH-1], b};
        sum   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
        ovf   = sum[WIDTH] ^ sum[WIDTH-1];
        y     = sum[WIDTH-1:0];
        if (SAT_EN && ovf) begin
            y = sum[WIDTH] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/sumador_sat_acc.sv
// Registered saturating add/sub/accumulate stage with valid pipeline,
// sticky overflow flag and saturating overflow-event counter.
module sumador_sat_acc
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH  = 22,
    parameter bit          SAT_EN = 1'b1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] d,
    output logic             valid_out,
    output logic             sat,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_cnt
);

    mode_e            op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             ovf;
    logic             ovf_hit;

    // Load is routed through the adder as A+0, which can never overflow.
    always_comb begin
        op     = mode_e'(mode);
        sub    = (op == MODE_SUB);
        opnd_b = b;
        case (op)
            MODE_ACC:  opnd_b = acc;
            MODE_LOAD: opnd_b = '0;
            default:   opnd_b = b;
        endcase
        ovf_hit = valid_in && ovf;
    end

    sat_addsub #(
        .WIDTH  (WIDTH),
        .SAT_EN (SAT_EN)
    ) u_addsub (
        .a   (a),
        .b   (opnd_b),
        .sub (sub),
        .y   (y),
        .ovf (ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d          <= '0;
            acc        <= '0;
            valid_out  <= 1'b0;
            sat        <= 1'b0;
            sticky_ovf <= 1'b0;
            ovf_cnt    <= '0;
        end else begin
            valid_out <= valid_in;
            sat       <= ovf_hit;
            if (valid_in) begin
                d <= y;
                if (op == MODE_ACC || op == MODE_LOAD) begin
                    acc <= y;
                end
            end
            if (ovf_hit) begin
                sticky_ovf <= 1'b1;
                if (clr_ovf) begin
                    ovf_cnt <= CNT_W'(1);
                end else if (ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + CNT_W'(1);
                end
            end else if (clr_ovf) begin
                sticky_ovf <= 1'b0;
                ovf_cnt    <= '0;
            end
        end
    end

endmodule
